// File: rtl/octal_reg_load_arbiter.sv
// octal_reg_load_arbiter
// Round-robin arbiter that shares one data bus and the load strobes of a bank
// of edge-clocked octal registers among several requesters. Each grant runs
// a fixed four-cycle sequence: IDLE (arbitrate) -> SETUP (drive bus) ->
// LOAD (strobe) -> HOLD (bus held, ack). The bus is therefore stable for a
// full cycle on both sides of the load edge.
// Optional build macro OCTAL_ARB_CLEAR_CMD_EN adds per-request clear
// commands (req_clr) and active-low per-register clears (reg_clr_n).
module octal_reg_load_arbiter #(
    parameter int NREQ = 4,
    parameter int NREG = 8,
    parameter int DW   = 8,
    localparam int AW  = $clog2(NREG),
    localparam int GW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 nclr,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
`ifdef OCTAL_ARB_CLEAR_CMD_EN
    input  logic [NREQ-1:0]      req_clr,
    output logic [NREG-1:0]      reg_clr_n,
`endif
    output logic [NREQ-1:0]      ack,
    output logic                 err,
    output logic [DW-1:0]        bus_data,
    output logic                 bus_oe,
    output logic [NREG-1:0]      reg_load,
    output logic                 busy,
    output logic [GW-1:0]        grant_id
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_LOAD  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    // One extra bit so NREG itself is representable for the range check.
    localparam logic [AW:0] NREG_W = (AW+1)'(NREG);

    state_t          r_state;
    logic [GW-1:0]   r_rr_ptr;
    logic [GW-1:0]   r_gnt;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_data;
    logic            r_clr;
    logic [NREQ-1:0] r_ack;
    logic            r_err;
    logic [DW-1:0]   r_bus_data;
    logic            r_bus_oe;
    logic [NREG-1:0] r_reg_load;
    logic            r_busy;
`ifdef OCTAL_ARB_CLEAR_CMD_EN
    logic [NREG-1:0] r_reg_clr_n;
`endif

    logic [AW-1:0]   w_addr_arr [NREQ];
    logic [DW-1:0]   w_data_arr [NREQ];
    logic            w_found;
    logic [GW-1:0]   w_pick;
    logic [GW-1:0]   w_idx;
    logic            w_pick_clr;
    logic            w_addr_bad;
    logic [NREG-1:0] w_reg_onehot;
    logic [NREQ-1:0] w_ack_onehot;
    logic [GW-1:0]   w_next_ptr;

    // Per-requester views of the flattened address/data buses.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
        assign w_addr_arr[gi] = req_addr[gi*AW +: AW];
        assign w_data_arr[gi] = req_data[gi*DW +: DW];
    end

`ifdef OCTAL_ARB_CLEAR_CMD_EN
    assign w_pick_clr = req_clr[w_pick];
`else
    assign w_pick_clr = 1'b0;
`endif

    assign w_addr_bad   = ({1'b0, r_addr} >= NREG_W);
    // Out-of-range shifts fall off the top; the strobe is also gated by w_addr_bad.
    assign w_reg_onehot = {{(NREG-1){1'b0}}, 1'b1} << r_addr;
    assign w_ack_onehot = {{(NREQ-1){1'b0}}, 1'b1} << r_gnt;
    assign w_next_ptr   = (r_gnt == GW'(NREQ-1)) ? '0 : r_gnt + 1'b1;

    // Round-robin scan: first requesting index at or after the pointer.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = GW'((int'(r_rr_ptr) + k) % NREQ);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    // Transaction sequencer; every output is set on the transition into the
    // state it belongs to, so all outputs come straight from flops.
    always_ff @(posedge clk or negedge nclr) begin
        if (!nclr) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_gnt       <= '0;
            r_addr      <= '0;
            r_data      <= '0;
            r_clr       <= 1'b0;
            r_ack       <= '0;
            r_err       <= 1'b0;
            r_bus_data  <= '0;
            r_bus_oe    <= 1'b0;
            r_reg_load  <= '0;
            r_busy      <= 1'b0;
`ifdef OCTAL_ARB_CLEAR_CMD_EN
            r_reg_clr_n <= '1;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state    <= S_SETUP;
                        r_gnt      <= w_pick;
                        r_addr     <= w_addr_arr[w_pick];
                        r_data     <= w_data_arr[w_pick];
                        r_clr      <= w_pick_clr;
                        r_busy     <= 1'b1;
                        // A clear command never drives the bus.
                        r_bus_oe   <= !w_pick_clr;
                        r_bus_data <= w_pick_clr ? '0 : w_data_arr[w_pick];
                    end
                end
                S_SETUP: begin
                    r_state <= S_LOAD;
                    if (!w_addr_bad) begin
`ifdef OCTAL_ARB_CLEAR_CMD_EN
                        if (r_clr) r_reg_clr_n <= ~w_reg_onehot;
                        else       r_reg_load  <= w_reg_onehot;
`else
                        r_reg_load <= w_reg_onehot;
`endif
                    end
                end
                S_LOAD: begin
                    r_state    <= S_HOLD;
                    r_reg_load <= '0;
`ifdef OCTAL_ARB_CLEAR_CMD_EN
                    r_reg_clr_n <= '1;
`endif
                    r_ack      <= w_ack_onehot;
                    r_err      <= w_addr_bad;
                    r_rr_ptr   <= w_next_ptr;
                end
                S_HOLD: begin
                    r_state    <= S_IDLE;
                    r_ack      <= '0;
                    r_err      <= 1'b0;
                    r_bus_oe   <= 1'b0;
                    r_bus_data <= '0;
                    r_busy     <= 1'b0;
                    r_gnt      <= '0;
                    r_clr      <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ack      = r_ack;
    assign err      = r_err;
    assign bus_data = r_bus_data;
    assign bus_oe   = r_bus_oe;
    assign reg_load = r_reg_load;
    assign busy     = r_busy;
    assign grant_id = r_gnt;
`ifdef OCTAL_ARB_CLEAR_CMD_EN
    assign reg_clr_n = r_reg_clr_n;
`endif

endmodule

// File: tb/tb_octal_reg_load_arbiter.sv
// Bench for octal_reg_load_arbiter (NREQ=4, NREG=6 so that out-of-range
// addresses 6 and 7 exist). A transaction-level model tracks the phase of
// the current grant and predicts every output each cycle.
module tb_octal_reg_load_arbiter;
    localparam int NREQ = 4;
    localparam int NREG = 6;
    localparam int DW   = 8;
    localparam int AW   = 3;
    localparam int GW   = 2;

    logic                clk = 1'b0;
    logic                nclr = 1'b0;
    logic [NREQ-1:0]     req = '0;
    logic [NREQ*AW-1:0]  req_addr = '0;
    logic [NREQ*DW-1:0]  req_data = '0;
    logic [NREQ-1:0]     ack;
    logic                err;
    logic [DW-1:0]       bus_data;
    logic                bus_oe;
    logic [NREG-1:0]     reg_load;
    logic                busy;
    logic [GW-1:0]       grant_id;
`ifdef OCTAL_ARB_CLEAR_CMD_EN
    logic [NREQ-1:0]     req_clr = '0;
    logic [NREG-1:0]     reg_clr_n;
`endif

    always #5 clk = ~clk;

    octal_reg_load_arbiter #(.NREQ(NREQ), .NREG(NREG), .DW(DW)) dut (
        .clk(clk), .nclr(nclr), .req(req), .req_addr(req_addr), .req_data(req_data),
`ifdef OCTAL_ARB_CLEAR_CMD_EN
        .req_clr(req_clr), .reg_clr_n(reg_clr_n),
`endif
        .ack(ack), .err(err), .bus_data(bus_data), .bus_oe(bus_oe),
        .reg_load(reg_load), .busy(busy), .grant_id(grant_id)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit auto_drop = 1'b1;

    // Model: phase 0 = no transaction, 1/2/3 = first/second/third cycle after grant.
    int          m_phase = 0;
    int          m_gnt = 0;
    int          m_ptr = 0;
    int          m_addr = 0;
    logic [7:0]  m_data = '0;
    bit          m_clr = 1'b0;

    typedef struct {
        int          rq;
        logic [2:0]  addr;
        logic [7:0]  data;
        logic [5:0]  exp_load;
        logic [3:0]  exp_ack;
        logic        exp_err;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_gnt = 0; m_ptr = 0; m_addr = 0; m_data = '0; m_clr = 1'b0;
    endtask

    // Advance the model across one clock edge using the current inputs.
    task automatic model_advance();
        if (m_phase == 0) begin
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (m_ptr + k) % NREQ;
                if (req[i]) begin
                    m_gnt  = i;
                    m_addr = int'(req_addr[i*AW +: AW]);
                    m_data = req_data[i*DW +: DW];
`ifdef OCTAL_ARB_CLEAR_CMD_EN
                    m_clr  = req_clr[i];
`else
                    m_clr  = 1'b0;
`endif
                    m_phase = 1;
                    break;
                end
            end
        end else if (m_phase == 3) begin
            m_phase = 0;
        end else begin
            if (m_phase == 2) m_ptr = (m_gnt + 1) % NREQ;
            m_phase++;
        end
    endtask

    task automatic check_outputs();
        logic [NREG-1:0] e_load, e_clr;
        logic [NREQ-1:0] e_ack;
        logic [DW-1:0]   e_data;
        bit              e_oe, e_err, e_busy;
        int              e_gid;
        e_busy = (m_phase != 0);
        e_gid  = e_busy ? m_gnt : 0;
        e_oe   = e_busy && !m_clr;
        e_data = e_oe ? m_data : 8'h00;
        e_load = '0;
        e_clr  = '0;
        if (m_phase == 2 && m_addr < NREG) begin
            if (m_clr) e_clr  = 6'b1 << m_addr;
            else       e_load = 6'b1 << m_addr;
        end
        e_ack  = (m_phase == 3) ? (4'b1 << m_gnt) : 4'b0;
        e_err  = (m_phase == 3) && (m_addr >= NREG);
        chk("busy", busy, e_busy);
        chk("grant_id", grant_id, e_gid);
        chk("bus_oe", bus_oe, e_oe);
        chk("bus_data", bus_data, e_data);
        chk("reg_load", reg_load, e_load);
        chk("ack", ack, e_ack);
        chk("err", err, e_err);
`ifdef OCTAL_ARB_CLEAR_CMD_EN
        chk("reg_clr_n", reg_clr_n, ~e_clr);
`endif
    endtask

    task automatic step();
        model_advance();
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
        if (auto_drop && m_phase == 3) req[m_gnt] = 1'b0;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic set_req(input int i, input logic [2:0] a, input logic [7:0] d);
        req[i] = 1'b1;
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic do_reset();
        req = '0;
`ifdef OCTAL_ARB_CLEAR_CMD_EN
        req_clr = '0;
`endif
        nclr = 1'b0;
        model_reset();
        #1;
        check_outputs();
        @(posedge clk);
        #1;
        nclr = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end

    initial begin
        int ack_cyc[4];
        int ack_who[4];
        int nacks;
        bit seen;

        tbl[0] = '{1, 3'd3, 8'hA5, 6'h08, 4'b0010, 1'b0};
        tbl[1] = '{0, 3'd0, 8'h3C, 6'h01, 4'b0001, 1'b0};
        tbl[2] = '{3, 3'd5, 8'hFF, 6'h20, 4'b1000, 1'b0};
        tbl[3] = '{2, 3'd7, 8'h11, 6'h00, 4'b0100, 1'b1};
        tbl[4] = '{1, 3'd6, 8'h00, 6'h00, 4'b0010, 1'b1};
        tbl[5] = '{2, 3'd2, 8'h5A, 6'h04, 4'b0100, 1'b0};

        // Reset state.
        #12;
        check_outputs();
        nclr = 1'b1;

        // Table-driven single transactions, including out-of-range addresses.
        for (int t = 0; t < 6; t++) begin
            set_req(tbl[t].rq, tbl[t].addr, tbl[t].data);
            step();
            chk("tbl_oe", bus_oe, 1);
            chk("tbl_gid", grant_id, tbl[t].rq);
            req_data[tbl[t].rq*DW +: DW] = ~tbl[t].data;
            req_addr[tbl[t].rq*AW +: AW] = 3'd1;
            step();
            chk("tbl_load", reg_load, tbl[t].exp_load);
            step();
            chk("tbl_ack", ack, tbl[t].exp_ack);
            chk("tbl_err", err, tbl[t].exp_err);
            chk("tbl_latched", bus_data, tbl[t].data);
            step();
            chk("tbl_idle_oe", bus_oe, 0);
        end

        // Round robin with all four requesting.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 3'(i), 8'(8'h10 + i));
        nacks = 0;
        for (int k = 0; k < 40 && nacks < 4; k++) begin
            step();
            chk("rr_onehot", ($countones(reg_load) <= 1), 1);
            if (ack != 0) begin
                ack_cyc[nacks] = cyc;
                for (int i = 0; i < NREQ; i++) if (ack[i]) ack_who[nacks] = i;
                nacks++;
            end
        end
        chk("rr_count", nacks, 4);
        for (int k = 0; k < nacks; k++) begin
            chk("rr_order", ack_who[k], k);
            if (k > 0) chk("rr_spacing", ack_cyc[k] - ack_cyc[k-1], 4);
        end

        // Fairness: req[0] held, req[2] joins during requester 0's second grant.
        do_reset();
        auto_drop = 1'b0;
        set_req(0, 3'd1, 8'h42);
        run(5);
        set_req(2, 3'd4, 8'h24);
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (ack != 0) begin
                chk("fair_prev_ack", ack, 4'b0001);
                step();
                step();
                chk("fair_gid", grant_id, 2);
                seen = 1'b1;
                break;
            end
        end
        chk("fair_seen", seen, 1);
        req[0] = 1'b0;
        auto_drop = 1'b1;
        run(8);

        // Reset during LOAD: strobe and bus vanish at once, pointer returns to 0.
        do_reset();
        set_req(0, 3'd1, 8'h55);
        run(4);
        set_req(1, 3'd2, 8'h77);
        run(2);
        chk("rst_pre_load", reg_load, 6'h04);
        #2;
        nclr = 1'b0;
        model_reset();
        #1;
        chk("rst_load", reg_load, 0);
        chk("rst_oe", bus_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ack", ack, 0);
        @(posedge clk);
        #1;
        chk("rst_noack", ack, 0);
        set_req(0, 3'd4, 8'h99);
        nclr = 1'b1;
        step();
        chk("rst_ptr", grant_id, 0);
        run(8);

`ifdef OCTAL_ARB_CLEAR_CMD_EN
        // Clear command: no bus drive, active-low clear strobe instead of load.
        do_reset();
        set_req(0, 3'd5, 8'hEE);
        req_clr[0] = 1'b1;
        step();
        chk("clr_oe1", bus_oe, 0);
        step();
        chk("clr_strobe", reg_clr_n, 6'h1F);
        chk("clr_noload", reg_load, 0);
        step();
        chk("clr_ack", ack, 4'b0001);
        req_clr[0] = 1'b0;
        run(2);
`endif

        // Randomized traffic against the model.
        do_reset();
        auto_drop = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] && $urandom_range(0, 3) == 0) begin
                    set_req(i, 3'($urandom_range(0, 7)), 8'($urandom));
`ifdef OCTAL_ARB_CLEAR_CMD_EN
                    req_clr[i] = ($urandom_range(0, 3) == 0);
`endif
                end else if (req[i] && $urandom_range(0, 15) == 0) begin
                    req_addr[i*AW +: AW] = 3'($urandom_range(0, 7));
                    req_data[i*DW +: DW] = 8'($urandom);
                end else if (req[i] && $urandom_range(0, 63) == 0) begin
                    req[i] = 1'b0;
                end
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/octal_reg_load_arbiter.md
Name: octal_reg_load_arbiter

Overview:
Shares one DW-bit data bus and the load strobes of NREG octal registers (74LS273-style, edge-clocked, active-low clear) among NREQ requesters. Each transaction is a 4-cycle sequence: arbitrate, drive bus, strobe the target register, hold the bus. It sits between microcode/control sources and the register bank, so register loads never collide on the bus and keep setup/hold margin around the load edge.

Parameters:
NREQ, 4, number of requesters (2..8)
NREG, 8, number of target registers (2..16); AW = clog2(NREG) is derived locally
DW, 8, bus/register data width

Ports:
clk  in  1  system clock; all state changes on its rising edge
nclr  in  1  asynchronous active-low reset
req  in  NREQ  per-requester load request, level; held high until ack
req_addr  in  NREQ*AW  target register index, slice i belongs to requester i
req_data  in  NREQ*DW  load data, slice i belongs to requester i
ack  out  NREQ  one-cycle completion pulse to the granted requester
err  out  1  one-cycle pulse, coincident with ack, when the granted address is >= NREG
bus_data  out  DW  shared register input bus
bus_oe  out  1  high while bus_data is valid
reg_load  out  NREG  one-hot load enable; registers capture bus_data on the clk edge ending the LOAD cycle
busy  out  1  high in every state except IDLE
grant_id  out  clog2(NREQ)  index of the current grantee; 0 in IDLE

Behaviour:
- Async reset (nclr low): state=IDLE; rr_ptr=0; ack, err, bus_data, bus_oe, reg_load, busy, grant_id all 0. Reset takes effect immediately, including mid-transaction: no load strobe completes and no ack is issued.
- FSM states: IDLE -> SETUP -> LOAD -> HOLD -> IDLE.
- IDLE: round-robin pick starting at rr_ptr, taking the first i with req[i]=1. On a pick, latch gnt=i, addr=req_addr slice i, data=req_data slice i, then go to SETUP. With no req, stay in IDLE.
- SETUP: bus_oe=1, bus_data=latched data, busy=1, no strobe.
- LOAD: bus held. If addr<NREG, reg_load[addr]=1 for exactly this cycle; otherwise reg_load stays 0.
- HOLD: bus still driven; reg_load=0. ack[gnt]=1 for this single cycle; err=1 if addr>=NREG. Set rr_ptr=(gnt+1) mod NREQ.
- The next cycle is IDLE, where bus_oe=0 and bus_data=0.
- Latency: req rises in cycle n -> SETUP n+1 -> LOAD n+2 -> HOLD/ack n+3. Register content is updated at the end of n+2. Back-to-back transactions give 1 load per 4 cycles.
- Data and address are latched at grant. Changes to req_data or req_addr after grant are ignored.
- If req drops after grant, the transaction still completes and ack is still pulsed.
- If a requester still holds req in the IDLE cycle after its ack, it is treated as a new request. It loses to any other pending requester because of the round-robin pointer.
- Outputs are registered. reg_load, ack and err are glitch-free single-cycle pulses.
- At most one bit of reg_load and at most one bit of ack is high in any cycle.

Optional Feature:
- Macro: OCTAL_ARB_CLEAR_CMD_EN.
- When defined, two ports are added:
  - req_clr, input, NREQ bits: clear command, latched at grant together with the address.
  - reg_clr_n, output, NREG bits: active-low per-register clear, reset value all 1s.
- For a granted clear command, LOAD drives reg_clr_n[addr]=0 for that one cycle instead of reg_load[addr]=1. bus_oe stays 0 for the whole transaction. Timing of ack and err is unchanged.
- When undefined, req_clr and reg_clr_n do not exist and every transaction is a load.

Test Plan:
- Single load: reset, then req[1]=1, addr1=3, data1=0xA5 -> bus_oe high for 3 cycles, then reg_load=0x08 for 1 cycle 2 cycles after req, then ack=0b0010 1 cycle later; err=0.
- Round-robin: req=0b1111 held, each requester deasserting after its own ack -> grant order 0,1,2,3, acks spaced 4 cycles apart, no reg_load overlap.
- Fairness: req[0] held high continuously, req[2] asserted at cycle 5 -> requester 2 is granted immediately after requester 0's current transaction finishes.
- Bad address (NREG=6): addr=7 -> reg_load stays 0; ack and err both pulse in HOLD.
- Reset mid-op: nclr low during the LOAD cycle -> reg_load, bus_oe, busy go 0 asynchronously; no ack; after release, IDLE with rr_ptr=0.
- With OCTAL_ARB_CLEAR_CMD_EN: req_clr[0]=1, addr=5 -> reg_clr_n=0xDF for one cycle, bus_oe=0 throughout, ack[0] pulses.
